irq_arbiter5: RTL and testbench
===============================

# irq_arbiter5

Five-source interrupt controller that sits between peripheral interrupt lines and the single `interrupt` / `interrupt_ack` pair of a KCPSM3 processor. It synchronises and polarity-normalises each source, supports mixed active-low and active-high lines, and round-robin arbitrates among pending enabled sources. It holds one interrupt in service until the handler writes end-of-interrupt (EOI). Software sees pending, mask and vector registers through the KCPSM3 port bus.

## Interface
Parameters:
- `BASE_ADDR`, 8'h80: port_id of register 0; registers occupy BASE_ADDR..BASE_ADDR+2.
- `ACTIVE_LOW_MASK`, 5'b00111: bit i = 1 means source i is asserted low.
- `EDGE_MASK`, 5'b00000: bit i = 1 means source i is edge-triggered (latched); 0 means level.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `irq_in` in 5: raw asynchronous interrupt sources.
- `interrupt` out 1: to KCPSM3 interrupt input.
- `interrupt_ack` in 1: one-cycle pulse from KCPSM3.
- `port_id` in 8: KCPSM3 port address.
- `write_strobe` in 1: KCPSM3 write qualifier.
- `read_strobe` in 1: KCPSM3 read qualifier (observed only, no read side effects).
- `out_port` in 8: KCPSM3 write data.
- `data_out` out 8: read data, muxed by the system into KCPSM3 in_port.

## Operation
- **Input conditioning, per source:**
  - 2-flop synchroniser, then XOR with ACTIVE_LOW_MASK, giving normalised `act[i]`, where 1 = asserted.
  - Synchroniser flops reset to the inactive raw level so reset release creates no false edge.
- **Pending:**
  - Edge source: `pend[i]` sets on a 0→1 of `act[i]`. It clears on EOI while i is in service.
  - Level source: `pend[i]` equals registered `act[i]`. EOI has no effect on it.
  - If a set and an EOI clear of the same bit land in the same cycle, set wins.
- **Eligibility:** `pend & mask`.
- **Registers** (writes qualified by write_strobe):
  - BASE+0, pending: R = {3'b0, pend}; writes ignored.
  - BASE+1, mask: R/W = {3'b0, mask}; only bits [4:0] are stored.
  - BASE+2, vector/EOI: R = {busy, 4'b0, vec[2:0]}, where busy = state≠IDLE. Any write is an EOI.
  - Other addresses: `data_out` = 8'h00.
- **FSM states:** IDLE, ASSERT, SERVICE.
  - IDLE → ASSERT when eligible ≠ 0.
    - Select the first eligible source searching from `last+1` modulo 5.
    - Latch that index into `vec`.
  - ASSERT: `interrupt` = 1. On `interrupt_ack` → SERVICE.
    - No withdrawal: if the source deasserts or is masked, `interrupt` stays high and `vec` stays unchanged.
  - SERVICE: `interrupt` = 0.
    - On EOI: clear `pend[vec]` if it is an edge source, set `last` = `vec`, → IDLE.
  - EOI in IDLE or ASSERT is ignored.
  - `interrupt_ack` outside ASSERT is ignored.
- **Reset values:** `interrupt` 0, `data_out` 0, `mask` 0, `pend` 0, `vec` 0, `last` 4 (source 0 wins first), state IDLE.
- **Reset mid-operation:** returns to IDLE immediately and all pending state is lost.

## Timing
- Raw edge sampled at clock edge N:
  - sync1 at N, sync2 at N+1, `pend` at N+2.
  - ASSERT entered and `interrupt` high after edge N+3.
- `interrupt` is a registered state decode and is glitch-free.
- `interrupt_ack` at edge M: state is SERVICE and `interrupt` low after M.
- EOI write at edge E: state is IDLE after E. Next ASSERT after E+1 at the earliest, so there is a minimum 1-cycle low gap between interrupts.
- `data_out` is registered from `port_id`, 1-cycle latency. Valid within KCPSM3's 2-cycle port_id window.
- Mask writes take effect for arbitration on the cycle after the write edge.

## Structure
- Package `irq_arb_pkg`:
  - state enum {IDLE, ASSERT, SERVICE}.
  - `NSRC` = 5.
  - register offsets `REG_PEND`=0, `REG_MASK`=1, `REG_VEC`=2.
- Sub-module `irq_input_cond`, instantiated ×5. Per-instance synchroniser, polarity, edge detect and pending flop; parameters `ACTIVE_LOW` and `EDGE`.
- Top level holds the round-robin selector, FSM and register file.

## Test plan
- Reset, mask=5'h1F, pulse irq_in[3] high (active-high, edge) → `interrupt`=1 four edges later. Ack → `interrupt`=0. Read BASE+2 → 8'h83. Write BASE+2 → read BASE+0 = 8'h00.
- irq_in[0] driven low (active-low, level), mask bit 0 clear → `interrupt` stays 0. Set mask bit 0 → `interrupt`=1 and vector reads 8'h80.
- Sources 1 and 4 pending simultaneously, `last`=4 → vec=1 first; after EOI, vec=4; after EOI with source 1 re-pending → vec=1.
- Edge re-fires on source 2 in the same cycle as its EOI → `pend[2]` stays 1 and a new interrupt follows.
- Assert `reset` while in SERVICE → `interrupt`=0, `data_out`=0, mask reads 8'h00, no spurious interrupt after release.
- Pulse `interrupt_ack` in IDLE and EOI in ASSERT → FSM unaffected.

Source files
------------

// File: rtl/irq_arb_pkg.sv
// Shared types, constants and the round-robin selector for the five-source interrupt arbiter.
package irq_arb_pkg;

    localparam int NSRC = 5;

    localparam logic [7:0] REG_PEND = 8'd0;
    localparam logic [7:0] REG_MASK = 8'd1;
    localparam logic [7:0] REG_VEC  = 8'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // First eligible source searching upward from last+1, wrapping modulo NSRC.
    function automatic logic [2:0] rr_pick(input logic [4:0] elig, input logic [2:0] last);
        logic [2:0] idx;
        logic [2:0] pick;
        logic       found;
        idx   = last;
        pick  = 3'd0;
        found = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            idx = (idx >= 3'd4) ? 3'd0 : idx + 3'd1;
            if (!found && elig[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/irq_input_cond.sv
// Per-source conditioning: 2-flop synchroniser, polarity normalisation, edge detect and pending flop.
module irq_input_cond
    import irq_arb_pkg::*;
#(
    parameter logic ACTIVE_LOW = 1'b0,
    parameter logic EDGE       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_raw,
    input  logic eoi_clr,
    output logic pend
);

    logic sync1_r;
    logic sync2_r;
    logic act_d_r;
    logic act_s;
    logic rise_s;

    assign act_s  = sync2_r ^ ACTIVE_LOW;
    assign rise_s = act_s & ~act_d_r;

    // Synchroniser resets to the inactive raw level so reset release never looks like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= ACTIVE_LOW;
            sync2_r <= ACTIVE_LOW;
            act_d_r <= 1'b0;
            pend    <= 1'b0;
        end else begin
            sync1_r <= irq_raw;
            sync2_r <= sync1_r;
            act_d_r <= act_s;
            if (EDGE) begin
                pend <= rise_s | (pend & ~eoi_clr);
            end else begin
                pend <= act_s;
            end
        end
    end

endmodule

// File: rtl/irq_arbiter5.sv
// Five-source round-robin interrupt controller for a KCPSM3: FSM, arbitration and port-mapped registers.
module irq_arbiter5
    import irq_arb_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR       = 8'h80,
    parameter logic [4:0] ACTIVE_LOW_MASK = 5'b00111,
    parameter logic [4:0] EDGE_MASK       = 5'b00000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] irq_in,
    output logic       interrupt,
    input  logic       interrupt_ack,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic       read_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] data_out
);

    irq_state_t state_r;
    logic [4:0] pend_s;
    logic [4:0] mask_r;
    logic [4:0] eligible_s;
    logic [4:0] eoi_clr_s;
    logic [2:0] vec_r;
    logic [2:0] last_r;
    logic [7:0] addr_off_s;
    logic       eoi_s;
    logic       eoi_service_s;
    logic       unused_s;

    assign addr_off_s    = port_id - BASE_ADDR;
    assign eoi_s         = write_strobe && (addr_off_s == REG_VEC);
    assign eoi_service_s = eoi_s && (state_r == SERVICE);
    assign eligible_s    = pend_s & mask_r;
    assign unused_s      = ^{read_strobe, out_port[7:5]};

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        assign eoi_clr_s[i] = eoi_service_s && (vec_r == 3'(i));

        irq_input_cond #(
            .ACTIVE_LOW (ACTIVE_LOW_MASK[i]),
            .EDGE       (EDGE_MASK[i])
        ) u_cond (
            .clk     (clk),
            .reset   (reset),
            .irq_raw (irq_in[i]),
            .eoi_clr (eoi_clr_s[i]),
            .pend    (pend_s[i])
        );
    end

    // Arbitration FSM; interrupt is a registered decode of the ASSERT state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            interrupt <= 1'b0;
            vec_r     <= 3'd0;
            last_r    <= 3'd4;
        end else begin
            case (state_r)
                IDLE: begin
                    if (eligible_s != 5'd0) begin
                        state_r   <= ASSERT;
                        interrupt <= 1'b1;
                        vec_r     <= rr_pick(eligible_s, last_r);
                    end else begin
                        interrupt <= 1'b0;
                    end
                end
                ASSERT: begin
                    // No withdrawal: once raised, only the ack lowers it.
                    if (interrupt_ack) begin
                        state_r   <= SERVICE;
                        interrupt <= 1'b0;
                    end else begin
                        interrupt <= 1'b1;
                    end
                end
                SERVICE: begin
                    interrupt <= 1'b0;
                    if (eoi_s) begin
                        state_r <= IDLE;
                        last_r  <= vec_r;
                    end else begin
                        state_r <= SERVICE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end

    // Mask register write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_r <= 5'd0;
        end else if (write_strobe && (addr_off_s == REG_MASK)) begin
            mask_r <= out_port[4:0];
        end else begin
            mask_r <= mask_r;
        end
    end

    // Registered read mux, one cycle behind port_id.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= 8'h00;
        end else begin
            case (addr_off_s)
                REG_PEND: data_out <= {3'b000, pend_s};
                REG_MASK: data_out <= {3'b000, mask_r};
                REG_VEC:  data_out <= {(state_r != IDLE), 4'b0000, vec_r};
                default:  data_out <= 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arbiter5.sv
// Directed bench for irq_arbiter5: sources 1-4 edge-triggered, source 0 level; 0-2 active-low.
module tb_irq_arbiter5;

    localparam logic [7:0] BASE = 8'h80;
    localparam logic [4:0] IDLE_LVL = 5'b00111;

    logic       clk;
    logic       reset;
    logic [4:0] irq_in;
    logic       interrupt;
    logic       interrupt_ack;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] data_out;
    logic [7:0] rd_val;

    int n_checks;
    int n_fail;

    irq_arbiter5 #(
        .BASE_ADDR       (BASE),
        .ACTIVE_LOW_MASK (5'b00111),
        .EDGE_MASK       (5'b11110)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .irq_in        (irq_in),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .port_id       (port_id),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .out_port      (out_port),
        .data_out      (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        port_id      = addr;
        out_port     = data;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
        port_id      = 8'h00;
    endtask

    task automatic rd(input logic [7:0] addr, output logic [7:0] data);
        port_id     = addr;
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        data        = data_out;
        port_id     = 8'h00;
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    // Drive one source to its asserted level for a single sampling edge.
    task automatic pulse(input int src);
        irq_in[src] = ~IDLE_LVL[src];
        tick();
        irq_in[src] = IDLE_LVL[src];
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        irq_in        = IDLE_LVL;
        interrupt_ack = 1'b0;
        port_id       = 8'h00;
        write_strobe  = 1'b0;
        read_strobe   = 1'b0;
        out_port      = 8'h00;
        tick(2);
        check("rst_int", {7'd0, interrupt}, 8'h00);
        check("rst_dout", data_out, 8'h00);
        reset = 1'b0;
        tick();
        rd(BASE + 8'd1, rd_val); check("rst_mask", rd_val, 8'h00);
        rd(BASE + 8'd2, rd_val); check("rst_vec", rd_val, 8'h00);
        rd(8'h40, rd_val);       check("other_addr", rd_val, 8'h00);

        // Edge source 3, active-high.
        wr(BASE + 8'd1, 8'h1F);
        pulse(3);
        tick(2);
        check("s3_not_yet", {7'd0, interrupt}, 8'h00);
        tick();
        check("s3_int", {7'd0, interrupt}, 8'h01);
        ack();
        check("s3_ack", {7'd0, interrupt}, 8'h00);
        rd(BASE + 8'd2, rd_val); check("s3_vec", rd_val, 8'h83);
        rd(BASE + 8'd0, rd_val); check("s3_pend", rd_val, 8'h08);
        wr(BASE + 8'd2, 8'h00);
        rd(BASE + 8'd0, rd_val); check("s3_pend_eoi", rd_val, 8'h00);
        check("s3_idle", {7'd0, interrupt}, 8'h00);

        // Level source 0, active-low, masked then unmasked; upper mask bits not stored.
        wr(BASE + 8'd1, 8'hFE);
        rd(BASE + 8'd1, rd_val); check("mask_rd", rd_val, 8'h1E);
        irq_in[0] = 1'b0;
        tick(6);
        check("s0_masked", {7'd0, interrupt}, 8'h00);
        rd(BASE + 8'd0, rd_val); check("s0_pend", rd_val, 8'h01);
        wr(BASE + 8'd1, 8'h1F);
        tick();
        check("s0_int", {7'd0, interrupt}, 8'h01);
        rd(BASE + 8'd2, rd_val); check("s0_vec", rd_val, 8'h80);
        wr(BASE + 8'd2, 8'h00);
        check("eoi_in_assert", {7'd0, interrupt}, 8'h01);
        rd(BASE + 8'd2, rd_val); check("vec_after_eoi_assert", rd_val, 8'h80);
        ack();
        check("s0_ack", {7'd0, interrupt}, 8'h00);
        irq_in[0] = 1'b1;
        tick(4);
        wr(BASE + 8'd2, 8'h00);
        tick(4);
        check("s0_done", {7'd0, interrupt}, 8'h00);
        ack();
        rd(BASE + 8'd2, rd_val); check("ack_in_idle", rd_val, 8'h00);
        check("ack_in_idle_int", {7'd0, interrupt}, 8'h00);

        // Reset while in SERVICE.
        pulse(3);
        tick(3);
        check("s3b_int", {7'd0, interrupt}, 8'h01);
        ack();
        reset = 1'b1;
        #1;
        check("midrst_int", {7'd0, interrupt}, 8'h00);
        check("midrst_dout", data_out, 8'h00);
        tick();
        reset = 1'b0;
        rd(BASE + 8'd1, rd_val); check("midrst_mask", rd_val, 8'h00);
        rd(BASE + 8'd0, rd_val); check("midrst_pend", rd_val, 8'h00);
        wr(BASE + 8'd1, 8'h1F);
        tick(6);
        check("no_spurious", {7'd0, interrupt}, 8'h00);

        // Round robin: sources 1 and 4 together with last=4.
        irq_in[1] = 1'b0;
        irq_in[4] = 1'b1;
        tick();
        irq_in = IDLE_LVL;
        tick(3);
        check("rr_int", {7'd0, interrupt}, 8'h01);
        rd(BASE + 8'd2, rd_val); check("rr_vec1", rd_val, 8'h81);
        ack();
        wr(BASE + 8'd2, 8'h00);
        check("rr_gap", {7'd0, interrupt}, 8'h00);
        tick();
        check("rr_int2", {7'd0, interrupt}, 8'h01);
        rd(BASE + 8'd2, rd_val); check("rr_vec4", rd_val, 8'h84);
        ack();
        pulse(1);
        tick(4);
        wr(BASE + 8'd2, 8'h00);
        tick();
        rd(BASE + 8'd2, rd_val); check("rr_vec1_again", rd_val, 8'h81);
        ack();
        wr(BASE + 8'd2, 8'h00);
        tick(3);
        rd(BASE + 8'd0, rd_val); check("rr_pend_clear", rd_val, 8'h00);

        // Source 2 re-fires in the same cycle its EOI lands.
        pulse(2);
        tick(3);
        check("s2_int", {7'd0, interrupt}, 8'h01);
        ack();
        tick(2);
        pulse(2);
        tick();
        wr(BASE + 8'd2, 8'h00);
        rd(BASE + 8'd0, rd_val); check("s2_refire_pend", rd_val, 8'h04);
        check("s2_refire_int", {7'd0, interrupt}, 8'h01);
        rd(BASE + 8'd2, rd_val); check("s2_refire_vec", rd_val, 8'h82);
        ack();
        wr(BASE + 8'd2, 8'h00);
        rd(BASE + 8'd0, rd_val); check("s2_final_pend", rd_val, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
